// File: rtl/i2c_slave_target.sv
// I2C target: synchronised/filtered bus inputs, 7-bit address match, write byte strobes and
// read byte handshake. Optional SCL clock stretching on read underflow: I2C_CLK_STRETCH_EN.
module i2c_slave_target #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       i2c_core_clk_i,
  input  logic       i2c_core_rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       scl_oe_o,
  input  logic [6:0] own_addr_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       rw_o,
  output logic       stop_o
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_DATA  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_DATA  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [FILTER_LEN-1:0]  scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic [2:0] state_q, state_d, bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic [6:0] own_addr_q, own_addr_d;
  logic       sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic       busy_q, busy_d, rw_q, rw_d, stop_q, stop_d;
  logic       start_det, stop_det, scl_rise, scl_fall, load_req;
`ifdef I2C_CLK_STRETCH_EN
  logic       stretch_q, stretch_d, scl_oe_q, scl_oe_d;
`endif

  // Synchroniser shift plus stability filter: a new level needs FILTER_LEN equal samples.
  always_comb begin
    scl_sync_d = SYNC_STAGES'({scl_sync_q, scl_i});
    sda_sync_d = SYNC_STAGES'({sda_sync_q, sda_i});
    scl_hist_d = FILTER_LEN'({scl_hist_q, scl_sync_q[SYNC_STAGES-1]});
    sda_hist_d = FILTER_LEN'({sda_hist_q, sda_sync_q[SYNC_STAGES-1]});
    if (&scl_hist_q) scl_f_d = 1'b1;
    else if (~|scl_hist_q) scl_f_d = 1'b0;
    else scl_f_d = scl_f_q;
    if (&sda_hist_q) sda_f_d = 1'b1;
    else if (~|sda_hist_q) sda_f_d = 1'b0;
    else sda_f_d = sda_f_q;
    scl_prev_d = scl_f_q;
    sda_prev_d = sda_f_q;
  end

  assign scl_rise  = scl_f_q & ~scl_prev_q;
  assign scl_fall  = ~scl_f_q & scl_prev_q;
  assign start_det = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;

  // Protocol FSM; START/STOP take priority over any SCL edge in the same cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    stop_d     = 1'b0;
    own_addr_d = own_addr_q;
    load_req   = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    stretch_d  = stretch_q;
    scl_oe_d   = 1'b0;
`endif
    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      stop_d    = 1'b1;
`ifdef I2C_CLK_STRETCH_EN
      stretch_d = 1'b0;
`endif
    end else if (start_det) begin
      state_d    = ADDR;
      bit_cnt_d  = 3'd0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      own_addr_d = own_addr_i;
`ifdef I2C_CLK_STRETCH_EN
      stretch_d  = 1'b0;
    end else if (stretch_q) begin
      // SCL stays held through the load cycle and is released one cycle after it.
      scl_oe_d = 1'b1;
      if (tx_valid_i) begin
        shift_d    = tx_data_i;
        tx_ready_d = 1'b1;
        sda_oe_d   = ~tx_data_i[7];
        stretch_d  = 1'b0;
      end else begin
        sda_oe_d   = 1'b0;
      end
`endif
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_f_q};
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              if (shift_q[6:0] == own_addr_q) begin
                state_d = ADDR_ACK;
                rw_d    = sda_f_q;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ADDR_ACK, WR_ACK: begin
          // First fall drives the ACK low, the second fall ends the ACK clock.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if ((state_q == ADDR_ACK) && rw_q) begin
              sda_oe_d = 1'b0;
              load_req = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              state_d   = WR_DATA;
              bit_cnt_d = 3'd0;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_f_q};
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = {shift_q[6:0], sda_f_q};
              rx_valid_d = 1'b1;
              state_d    = WR_ACK;
              bit_cnt_d  = 3'd0;
            end else begin
              bit_cnt_d  = bit_cnt_q + 3'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              state_d   = RD_ACK;
              bit_cnt_d = 3'd0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b1};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_f_q) state_d = IGNORE;
          else if (scl_fall) load_req = 1'b1;
          else state_d = state_q;
        end
        IDLE, IGNORE: state_d = state_q;
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
      if (load_req) begin
        state_d   = RD_DATA;
        bit_cnt_d = 3'd0;
        if (tx_valid_i) begin
          shift_d    = tx_data_i;
          tx_ready_d = 1'b1;
          sda_oe_d   = ~tx_data_i[7];
        end else begin
`ifdef I2C_CLK_STRETCH_EN
          stretch_d = 1'b1;
          scl_oe_d  = 1'b1;
          sda_oe_d  = 1'b0;
`else
          shift_d   = 8'hFF;
          sda_oe_d  = 1'b0;
`endif
        end
      end else begin
        tx_ready_d = 1'b0;
      end
    end
  end

  // State registers; reset releases the bus and presets the input path to an idle (high) bus.
  always_ff @(posedge i2c_core_clk_i) begin
    if (i2c_core_rst_i) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_hist_q <= {FILTER_LEN{1'b1}};
      sda_hist_q <= {FILTER_LEN{1'b1}};
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      own_addr_q <= 7'h00;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      stop_q     <= 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      stretch_q  <= 1'b0;
      scl_oe_q   <= 1'b0;
`endif
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      own_addr_q <= own_addr_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      stop_q     <= stop_d;
`ifdef I2C_CLK_STRETCH_EN
      stretch_q  <= stretch_d;
      scl_oe_q   <= scl_oe_d;
`endif
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = tx_ready_q;
  assign busy_o     = busy_q;
  assign rw_o       = rw_q;
  assign stop_o     = stop_q;
`ifdef I2C_CLK_STRETCH_EN
  assign scl_oe_o   = scl_oe_q;
`else
  assign scl_oe_o   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bit-banged open-drain master, strobe scoreboard with a
// decoupled monitor, and direct checks of bus-level ACK/read bits.
module tb_i2c_slave_target;
  localparam int H = 10;
  localparam logic [1:0] K_RX = 2'd0, K_TX = 2'd1, K_STOP = 2'd2;

  typedef struct packed { logic [1:0] kind; logic [7:0] data; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m, scl_i, sda_i;
  logic sda_oe_o, scl_oe_o, rx_valid_o, tx_ready_o, busy_o, rw_o, stop_o;
  logic [6:0] own_addr_i;
  logic [7:0] rx_data_o, tx_data_i;
  logic tx_valid_i;

  exp_t exp_q[$];
  logic [7:0] tx_q[$];
  int n_cmp = 0, n_err = 0;
  int sda_cnt = 0, scl_cnt = 0;

  always #5 clk = ~clk;

  assign scl_i = scl_m & ~scl_oe_o;
  assign sda_i = sda_m & ~sda_oe_o;

  i2c_slave_target dut (
    .i2c_core_clk_i(clk), .i2c_core_rst_i(rst),
    .scl_i(scl_i), .sda_i(sda_i), .sda_oe_o(sda_oe_o), .scl_oe_o(scl_oe_o),
    .own_addr_i(own_addr_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .busy_o(busy_o), .rw_o(rw_o), .stop_o(stop_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic got(input logic [1:0] k, input logic [7:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_strobe: got kind %0d data 0x%0h, required none", k, d);
    end else begin
      e = exp_q.pop_front();
      check("strobe", 32'({k, d}), 32'({e.kind, e.data}));
    end
  endtask

  task automatic push_exp(input logic [1:0] k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every output strobe and counts bus-drive cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (sda_oe_o) sda_cnt++;
      if (scl_oe_o) scl_cnt++;
      if (rx_valid_o) got(K_RX, rx_data_o);
      if (tx_ready_o) got(K_TX, 8'h00);
      if (stop_o) got(K_STOP, 8'h00);
    end
  end

  // Read-data source: presents the head of tx_q and drops it once consumed.
  initial begin
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_ready_o && tx_q.size() > 0) void'(tx_q.pop_front());
      tx_valid_i = (tx_q.size() != 0);
      tx_data_i  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    int t;
    sda_m = b;
    wait_cyc(H);
    scl_m = 1'b1;
    t = 0;
    while (scl_i !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_cmp++;
      n_err++;
      $display("FAIL scl_release_timeout: scl held low %0d cycles, required release", t);
    end
    wait_cyc(H);
    r = sda_i;
    wait_cyc(H);
    scl_m = 1'b0;
    wait_cyc(H);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(ack_bit, r);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_cyc(H);
    scl_m = 1'b1; wait_cyc(H);
    sda_m = 1'b0; wait_cyc(H);
    scl_m = 1'b0; wait_cyc(H);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_cyc(H);
    scl_m = 1'b1; wait_cyc(H);
    sda_m = 1'b1; wait_cyc(2 * H);
  endtask

  task automatic write_txn(input string tag);
    logic a;
    push_exp(K_RX, 8'h1B);
    push_exp(K_RX, 8'h42);
    push_exp(K_STOP, 8'h00);
    bus_start();
    write_byte(8'h20, a); check({tag, "_addr_ack"}, 32'(a), 32'd0);
    check({tag, "_rw"}, 32'(rw_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    write_byte(8'h1B, a); check({tag, "_d1_ack"}, 32'(a), 32'd0);
    write_byte(8'h42, a); check({tag, "_d2_ack"}, 32'(a), 32'd0);
    bus_stop();
    check({tag, "_busy_after_stop"}, 32'(busy_o), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data_o), 32'h42);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic a, r;
    logic [7:0] d;
    int base, n;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; own_addr_i = 7'h10;
    wait_cyc(5);
    check("reset_outputs", 32'({sda_oe_o, scl_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
                                busy_o, rw_o, stop_o}), 32'd0);
    rst = 1'b0;
    wait_cyc(20);

    // Addressed write of two bytes.
    write_txn("t1");

    // Address mismatch: never ACKs, ignores following data.
    base = sda_cnt;
    push_exp(K_STOP, 8'h00);
    bus_start();
    write_byte(8'h22, a); check("t2_nack", 32'(a), 32'd1);
    write_byte(8'h77, a); check("t2_data_nack", 32'(a), 32'd1);
    bus_stop();
    check("t2_sda_never_driven", 32'(sda_cnt - base), 32'd0);
    check("t2_exp_left", 32'(exp_q.size()), 32'd0);

    // Read two bytes, master NACKs the second.
    tx_q.push_back(8'hA5); tx_q.push_back(8'h3C);
    push_exp(K_TX, 8'h00); push_exp(K_TX, 8'h00); push_exp(K_STOP, 8'h00);
    bus_start();
    write_byte(8'h21, a); check("t3_addr_ack", 32'(a), 32'd0);
    check("t3_rw", 32'(rw_o), 32'd1);
    read_byte(1'b0, d); check("t3_byte1", 32'(d), 32'hA5);
    read_byte(1'b1, d); check("t3_byte2", 32'(d), 32'h3C);
    check("t3_sda_released", 32'(sda_oe_o), 32'd0);
    bus_stop();
    check("t3_busy_after_stop", 32'(busy_o), 32'd0);
    check("t3_exp_left", 32'(exp_q.size()), 32'd0);

    // Write, repeated START, read.
    tx_q.push_back(8'h99);
    push_exp(K_RX, 8'h55); push_exp(K_TX, 8'h00); push_exp(K_STOP, 8'h00);
    bus_start();
    write_byte(8'h20, a); check("t4_addr_ack", 32'(a), 32'd0);
    check("t4_rw0", 32'(rw_o), 32'd0);
    write_byte(8'h55, a); check("t4_d_ack", 32'(a), 32'd0);
    bus_start();
    write_byte(8'h21, a); check("t4_raddr_ack", 32'(a), 32'd0);
    check("t4_rw1", 32'(rw_o), 32'd1);
    read_byte(1'b1, d); check("t4_rdata", 32'(d), 32'h99);
    bus_stop();
    check("t4_exp_left", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a read byte (5th bit of 0xA5 is 0, so SDA is driven).
    tx_q.push_back(8'hA5);
    push_exp(K_TX, 8'h00);
    bus_start();
    write_byte(8'h21, a); check("t5_addr_ack", 32'(a), 32'd0);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, r);
    check("t5_sda_driven_before_rst", 32'(sda_oe_o), 32'd1);
    rst = 1'b1;
    wait_cyc(1);
    check("t5_oe_released", 32'({sda_oe_o, scl_oe_o}), 32'd0);
    wait_cyc(2);
    check("t5_reset_outputs", 32'({sda_oe_o, scl_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
                                   busy_o, rw_o, stop_o}), 32'd0);
    rst = 1'b0;
    wait_cyc(H);
    push_exp(K_STOP, 8'h00);
    bus_stop();
    check("t5_exp_left", 32'(exp_q.size()), 32'd0);
    write_txn("t5w");

    // Read with no data available after the address ACK.
    tx_q.delete();
`ifdef I2C_CLK_STRETCH_EN
    push_exp(K_TX, 8'h00);
`endif
    push_exp(K_STOP, 8'h00);
    bus_start();
    write_byte(8'h21, a); check("t6_addr_ack", 32'(a), 32'd0);
    base = scl_cnt;
    fork
      begin wait_cyc(200); tx_q.push_back(8'h3C); end
      begin read_byte(1'b1, d); end
    join
    n = scl_cnt - base;
`ifdef I2C_CLK_STRETCH_EN
    check("t6_data", 32'(d), 32'h3C);
    check("t6_stretch_window", 32'(n >= 195 && n <= 225), 32'd1);
`else
    check("t6_data", 32'(d), 32'hFF);
    check("t6_no_stretch", 32'(n), 32'd0);
`endif
    bus_stop();
    tx_q.delete();
    check("t6_exp_left", 32'(exp_q.size()), 32'd0);

    wait_cyc(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
